hv_lbist_mc: RTL and testbench

Parametrised multi-channel logic BIST controller for the HV die, next generation of the single-link HV BIST. On rising `i_bist_en` it walks all scan registers through an addressed req/ack handshake with a per-request ack timeout, and in parallel runs a fixed observation window in which each of `OWT_CH_NUM` one-wire receive channels must deliver enough good frames. At the end it latches per-channel and scan results, an error count and an overall pass flag, and emits a one-cycle done pulse. It sits between the HV test-mode decoder, the scan-register block and the OWT receivers.

---
 rtl/hv_lbist_mc.sv | 189 ++++++++++++++++++
 tb/tb_hv_lbist_mc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_lbist_mc.sv
// Multi-channel HV logic BIST: scan-register req/ack walk with a per-request timeout, alongside an OWT observation window.
// Latency: run starts one cycle after the i_bist_en rise; done comes at max(window, scan walk) + 1. The scan walk stalls on ack, bounded by REQ_TMO per register.
module hv_lbist_mc #(
    parameter  int CLK_M           = 48,
    parameter  int HV_SCAN_REG_NUM = 32,
    parameter  int OWT_CH_NUM      = 2,
    parameter  int OWT_OK_NUM      = 3,
    parameter  int TMO_US          = 25000,
    parameter  int REQ_TMO         = 64,
    localparam int SCAN_AW         = (HV_SCAN_REG_NUM > 1) ? $clog2(HV_SCAN_REG_NUM) : 1,
    localparam int ERR_W           = $clog2(HV_SCAN_REG_NUM + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bist_en,
    output logic                  o_bist_scan_reg_req,
    output logic [SCAN_AW-1:0]    o_bist_scan_reg_addr,
    input  logic                  i_scan_reg_bist_ack,
    input  logic                  i_scan_reg_bist_err,
    input  logic [OWT_CH_NUM-1:0] i_owt_rx_ack,
    input  logic [OWT_CH_NUM-1:0] i_owt_rx_status,
    output logic [OWT_CH_NUM-1:0] o_hv_owt_bist_rult,
    output logic                  o_hv_scan_bist_rult,
    output logic [ERR_W-1:0]      o_hv_scan_err_cnt,
    output logic                  o_hv_bist_pass,
    output logic                  o_hv_bist_busy,
    output logic                  o_hv_bist_done
);

    localparam int TMO_TH = TMO_US * CLK_M;
    localparam int WIN_W  = (TMO_TH > 1) ? $clog2(TMO_TH) : 1;
    localparam int TMR_W  = $clog2(REQ_TMO);
    localparam int OKC_W  = (OWT_OK_NUM > 0) ? $clog2(OWT_OK_NUM + 1) : 1;

    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(TMO_TH - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(REQ_TMO - 1);
    localparam logic [SCAN_AW-1:0] ADDR_LAST = SCAN_AW'(HV_SCAN_REG_NUM - 1);
    localparam logic [OKC_W-1:0]   OK_MAX    = OKC_W'(OWT_OK_NUM);
    localparam logic [ERR_W-1:0]   ERR_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_FIN, T_HOLD} top_st_t;
    typedef enum logic [1:0] {S_REQ, S_GAP, S_END} scan_st_t;

    top_st_t               r_top;
    scan_st_t              r_scan;
    logic                  r_en_d;
    logic [WIN_W-1:0]      r_win;
    logic [TMR_W-1:0]      r_tmr;
    logic [SCAN_AW-1:0]    r_addr;
    logic                  r_req;
    logic [ERR_W-1:0]      r_err;
    logic [OKC_W-1:0]      r_cnt [OWT_CH_NUM];
    logic [OWT_CH_NUM-1:0] r_owt_rult;
    logic                  r_scan_rult;
    logic [ERR_W-1:0]      r_err_cnt;
    logic                  r_pass;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start;
    logic                  w_expired;
    logic [OWT_CH_NUM-1:0] w_owt_ok;
    logic [ERR_W-1:0]      w_err_inc;

    assign w_start   = i_bist_en & ~r_en_d;
    assign w_expired = (r_win == WIN_LAST);
    assign w_err_inc = (r_err == ERR_MAX) ? r_err : r_err + 1'b1;

    always_comb begin
        w_owt_ok = '0;
        for (int i = 0; i < OWT_CH_NUM; i++) begin
            w_owt_ok[i] = (r_cnt[i] == OK_MAX);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_top       <= T_IDLE;
            r_scan      <= S_END;
            r_en_d      <= 1'b0;
            r_win       <= '0;
            r_tmr       <= '0;
            r_addr      <= '0;
            r_req       <= 1'b0;
            r_err       <= '0;
            for (int i = 0; i < OWT_CH_NUM; i++) begin
                r_cnt[i] <= '0;
            end
            r_owt_rult  <= '1;
            r_scan_rult <= 1'b1;
            r_err_cnt   <= '0;
            r_pass      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_en_d <= i_bist_en;
            r_done <= 1'b0;
            case (r_top)
                T_IDLE: begin
                    if (w_start) begin
                        r_top  <= T_RUN;
                        r_busy <= 1'b1;
                        r_scan <= S_REQ;
                        r_req  <= 1'b1;
                        r_addr <= '0;
                        r_tmr  <= '0;
                        r_win  <= '0;
                        r_err  <= '0;
                        for (int i = 0; i < OWT_CH_NUM; i++) begin
                            r_cnt[i] <= '0;
                        end
                    end
                end
                T_RUN: begin
                    if (!i_bist_en) begin
                        // abort leaves the last completed results untouched
                        r_top  <= T_IDLE;
                        r_busy <= 1'b0;
                        r_req  <= 1'b0;
                    end else if (w_expired && r_scan == S_END) begin
                        r_top       <= T_FIN;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_owt_rult  <= w_owt_ok;
                        r_scan_rult <= (r_err == '0);
                        r_err_cnt   <= r_err;
                        r_pass      <= (&w_owt_ok) & (r_err == '0);
                    end else begin
                        if (!w_expired) begin
                            r_win <= r_win + 1'b1;
                            for (int i = 0; i < OWT_CH_NUM; i++) begin
                                if (i_owt_rx_ack[i] && !i_owt_rx_status[i] && r_cnt[i] != OK_MAX) begin
                                    r_cnt[i] <= r_cnt[i] + 1'b1;
                                end
                            end
                        end
                        case (r_scan)
                            S_REQ: begin
                                // ack wins over a simultaneous timeout
                                if (i_scan_reg_bist_ack || r_tmr == TMR_LAST) begin
                                    r_req  <= 1'b0;
                                    r_scan <= S_GAP;
                                    if (!i_scan_reg_bist_ack || i_scan_reg_bist_err) begin
                                        r_err <= w_err_inc;
                                    end
                                end else begin
                                    r_tmr <= r_tmr + 1'b1;
                                end
                            end
                            S_GAP: begin
                                if (r_addr == ADDR_LAST) begin
                                    r_scan <= S_END;
                                end else begin
                                    r_addr <= r_addr + 1'b1;
                                    r_tmr  <= '0;
                                    r_req  <= 1'b1;
                                    r_scan <= S_REQ;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                T_FIN: begin
                    r_top <= T_HOLD;
                end
                T_HOLD: begin
                    if (!i_bist_en) begin
                        r_top <= T_IDLE;
                    end
                end
                default: begin
                    r_top <= T_IDLE;
                end
            endcase
        end
    end

    assign o_bist_scan_reg_req  = r_req;
    assign o_bist_scan_reg_addr = r_addr;
    assign o_hv_owt_bist_rult   = r_owt_rult;
    assign o_hv_scan_bist_rult  = r_scan_rult;
    assign o_hv_scan_err_cnt    = r_err_cnt;
    assign o_hv_bist_pass       = r_pass;
    assign o_hv_bist_busy       = r_busy;
    assign o_hv_bist_done       = r_done;

endmodule

// File: tb/tb_hv_lbist_mc.sv
// Directed bench for hv_lbist_mc: a long-window instance for the main scenarios and a short-window one for the late scan finish.
module tb_hv_lbist_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en, ack, err, req, scan_rult, pass, busy, done;
    logic [1:0] addr, owt_ack, owt_st, owt_rult;
    logic [2:0] err_cnt;

    logic       s_en, s_ack, s_err, s_req, s_scan_rult, s_pass, s_busy, s_done;
    logic [1:0] s_addr, s_owt_ack, s_owt_st, s_owt_rult;
    logic [2:0] s_err_cnt;

    hv_lbist_mc #(.CLK_M(1), .HV_SCAN_REG_NUM(4), .OWT_CH_NUM(2), .OWT_OK_NUM(3), .TMO_US(200), .REQ_TMO(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_bist_en(en),
        .o_bist_scan_reg_req(req), .o_bist_scan_reg_addr(addr),
        .i_scan_reg_bist_ack(ack), .i_scan_reg_bist_err(err),
        .i_owt_rx_ack(owt_ack), .i_owt_rx_status(owt_st),
        .o_hv_owt_bist_rult(owt_rult), .o_hv_scan_bist_rult(scan_rult),
        .o_hv_scan_err_cnt(err_cnt), .o_hv_bist_pass(pass),
        .o_hv_bist_busy(busy), .o_hv_bist_done(done));

    hv_lbist_mc #(.CLK_M(1), .HV_SCAN_REG_NUM(4), .OWT_CH_NUM(2), .OWT_OK_NUM(3), .TMO_US(10), .REQ_TMO(8)) u_dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_bist_en(s_en),
        .o_bist_scan_reg_req(s_req), .o_bist_scan_reg_addr(s_addr),
        .i_scan_reg_bist_ack(s_ack), .i_scan_reg_bist_err(s_err),
        .i_owt_rx_ack(s_owt_ack), .i_owt_rx_status(s_owt_st),
        .o_hv_owt_bist_rult(s_owt_rult), .o_hv_scan_bist_rult(s_scan_rult),
        .o_hv_scan_err_cnt(s_err_cnt), .o_hv_bist_pass(s_pass),
        .o_hv_bist_busy(s_busy), .o_hv_bist_done(s_done));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // responder / monitor state, updated 1 time unit after each rising edge
    int         lat1 = 3;
    logic [3:0] errm = '0;
    logic [3:0] noackm = '0;
    logic       stray = 1'b0;
    int         cyc = 0, rc1 = 0, rc2 = 0;
    int         nstreak = 0, streak = 0, gapcnt = 0;
    int         len_a [4];
    int         gap_a [4];
    int         seq_a [8];
    logic       prev_req = 1'b0, prev_busy = 1'b0, s_prev_busy = 1'b0;
    int         t_start = 0, t_done = 0, done_cnt = 0;
    int         s_t_start = 0, s_t_done = 0, s_done_cnt = 0;

    initial begin
        ack = 1'b0; err = 1'b0; s_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (req) begin
                rc1++;
                ack = ((rc1 == lat1) && !noackm[addr]) || stray;
                err = errm[addr];
                if (!prev_req) begin
                    streak = 1;
                    if (nstreak > 0) gap_a[addr] = gapcnt;
                    if (nstreak < 8) seq_a[nstreak] = int'(addr);
                    nstreak++;
                end else begin
                    streak++;
                end
                len_a[addr] = streak;
            end else begin
                rc1 = 0;
                ack = stray;
                err = 1'b0;
                gapcnt = prev_req ? 1 : gapcnt + 1;
            end
            prev_req = req;
            if (busy && !prev_busy) t_start = cyc;
            if (done) begin t_done = cyc; done_cnt++; end
            prev_busy = busy;
            if (s_req) begin
                rc2++;
                s_ack = (rc2 == 7);
            end else begin
                rc2 = 0;
                s_ack = 1'b0;
            end
            if (s_busy && !s_prev_busy) s_t_start = cyc;
            if (s_done) begin s_t_done = cyc; s_done_cnt++; end
            s_prev_busy = s_busy;
        end
    end

    task automatic clr_mon();
        nstreak = 0;
        for (int i = 0; i < 4; i++) begin len_a[i] = 0; gap_a[i] = 0; end
        for (int i = 0; i < 8; i++) seq_a[i] = 0;
    endtask

    task automatic start_run();
        @(negedge clk); en = 1'b0;
        @(negedge clk); en = 1'b1;
    endtask

    task automatic frames(input int ch, input int ng, input int nb);
        for (int k = 0; k < ng + nb; k++) begin
            @(negedge clk); owt_ack[ch] = 1'b1; owt_st[ch] = (k >= ng);
            @(negedge clk); owt_ack[ch] = 1'b0; owt_st[ch] = 1'b0;
        end
    endtask

    task automatic wait_fin(input string tag);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done_cnt - d0, 1);
    endtask

    task automatic chk_res(input string tag, input logic [1:0] o, input logic s, input logic [2:0] e, input logic p);
        chk({tag, "_owt"}, owt_rult, o);
        chk({tag, "_scan"}, scan_rult, s);
        chk({tag, "_ecnt"}, err_cnt, e);
        chk({tag, "_pass"}, pass, p);
    endtask

    initial begin
        int d0, n;
        rst_n = 1'b0; en = 1'b0; owt_ack = '0; owt_st = '0;
        s_en = 1'b0; s_err = 1'b0; s_owt_ack = '0; s_owt_st = '0;
        clr_mon();
        repeat (3) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_res("rst", 2'b11, 1'b1, 3'd0, 1'b1);
        rst_n = 1'b1;

        // clean run
        clr_mon();
        start_run();
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_req", req, 1);
        chk("t1_addr", addr, 0);
        frames(0, 3, 0);
        frames(1, 3, 0);
        wait_fin("t1_fin");
        chk("t1_done", done, 1);
        chk("t1_busy_off", busy, 0);
        chk("t1_lat", t_done - t_start, 200);
        chk("t1_seq", seq_a[0] | (seq_a[1] << 4) | (seq_a[2] << 8) | (seq_a[3] << 12), 32'h3210);
        chk("t1_nreq", nstreak, 4);
        chk("t1_gaps", gap_a[1] | (gap_a[2] << 4) | (gap_a[3] << 8), 32'h111);
        chk("t1_len", len_a[0] | (len_a[1] << 4) | (len_a[2] << 8) | (len_a[3] << 12), 32'h3333);
        chk_res("t1", 2'b11, 1'b1, 3'd0, 1'b1);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // err on addr 2, addr 3 never acked
        errm = 4'b0100; noackm = 4'b1000;
        clr_mon();
        start_run();
        frames(0, 3, 0);
        frames(1, 3, 0);
        wait_fin("t2_fin");
        chk("t2_len3", len_a[3], 8);
        chk("t2_nreq", nstreak, 4);
        chk_res("t2", 2'b11, 1'b0, 3'd2, 1'b0);
        errm = '0; noackm = '0;

        // channel 1 short on good frames
        clr_mon();
        start_run();
        frames(0, 7, 0);
        frames(1, 2, 5);
        wait_fin("t3_fin");
        chk_res("t3", 2'b01, 1'b1, 3'd0, 1'b0);
        repeat (20) @(negedge clk);
        chk_res("t3_hold", 2'b01, 1'b1, 3'd0, 1'b0);

        // abort at cycle 50
        start_run();
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_req", req, 0);
        d0 = done_cnt;
        repeat (250) @(negedge clk);
        chk("t5_nodone", done_cnt - d0, 0);
        chk_res("t5", 2'b01, 1'b1, 3'd0, 1'b0);
        clr_mon();
        en = 1'b1;
        @(negedge clk);
        chk("t5_re_busy", busy, 1);
        chk("t5_re_req", req, 1);
        chk("t5_re_addr", addr, 0);

        // reset mid-run, then stray strobes in idle
        repeat (9) @(negedge clk);
        rst_n = 1'b0; en = 1'b0;
        @(negedge clk);
        chk("t6_req", req, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk_res("t6", 2'b11, 1'b1, 3'd0, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        stray = 1'b1; owt_ack = 2'b11;
        @(negedge clk);
        stray = 1'b0; owt_ack = 2'b00;
        repeat (4) @(negedge clk);
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_req", req, 0);
        chk("t6_idle_done", done_cnt - d0, 0);
        chk_res("t6_idle", 2'b11, 1'b1, 3'd0, 1'b1);

        // short window: scan walk outlasts the window
        @(negedge clk); s_en = 1'b1;
        @(negedge clk); s_owt_ack = 2'b11;
        repeat (2) @(negedge clk);
        @(negedge clk); s_owt_ack = 2'b00;
        d0 = s_done_cnt;
        n = 0;
        while (s_done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_fin", s_done_cnt - d0, 1);
        chk("t4_lat", s_t_done - s_t_start, 33);
        chk("t4_owt", s_owt_rult, 2'b11);
        chk("t4_scan", s_scan_rult, 1);
        chk("t4_ecnt", s_err_cnt, 0);
        chk("t4_pass", s_pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
